// File: rtl/sram_param.sv
// ============================================================================
// Module      : sram_param (package)
// Description : Shared SRAM geometry and frame-loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_param;

    localparam int SRAM_ADDR_COUNT  = 20;      // address bus width in bits
    localparam int SRAM_DATA_WIDTH  = 16;
    localparam int FRAME_WORD_COUNT = 307200;  // 640x480 pixels, one word each

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RECV_LO = 3'd1,
        RECV_HI = 3'd2,
        SETUP   = 3'd3,
        WRITE   = 3'd4,
        HOLD    = 3'd5,
        DONE    = 3'd6
    } LoaderState;

endpackage : sram_param

`default_nettype wire

// File: rtl/sram_frame_loader.sv
// ============================================================================
// Module      : sram_frame_loader
// Description : Packs a byte stream into 16-bit words and writes them to SRAM
//               from address 0 with an explicit setup / WE_N / hold sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_frame_loader
    import sram_param::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_COUNT,
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int WORD_COUNT = FRAME_WORD_COUNT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic [ADDR_WIDTH-1:0] o_SRAM_ADDR,
    output logic [DATA_WIDTH-1:0] o_SRAM_DQ,
    output logic                  o_SRAM_DQ_OE,
    output logic                  o_SRAM_WE_N,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_word_count
);

    localparam logic [ADDR_WIDTH-1:0] c_last_count = ADDR_WIDTH'(WORD_COUNT - 1);

    LoaderState            r_state;
    logic [7:0]            r_lo_byte;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0] r_dq;
    logic                  r_byte_ready;
    logic                  r_dq_oe;
    logic                  r_we_n;
    logic                  r_busy;
    logic                  r_done;

    LoaderState            w_next_state;
    logic [7:0]            w_next_lo_byte;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [ADDR_WIDTH-1:0] w_next_count;
    logic [DATA_WIDTH-1:0] w_next_dq;
    logic                  w_accept;

    assign w_accept = i_byte_valid && r_byte_ready;

    always_comb begin
        w_next_state   = r_state;
        w_next_lo_byte = r_lo_byte;
        w_next_addr    = r_addr;
        w_next_count   = r_count;
        w_next_dq      = r_dq;

        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_next_state = RECV_LO;
                    w_next_addr  = '0;
                    w_next_count = '0;
                end
            end
            RECV_LO: begin
                if (w_accept) begin
                    w_next_lo_byte = i_byte;
                    w_next_state   = RECV_HI;
                end
            end
            RECV_HI: begin
                if (w_accept) begin
                    w_next_dq    = {i_byte, r_lo_byte};
                    w_next_state = SETUP;
                end
            end
            SETUP: w_next_state = WRITE;
            WRITE: w_next_state = HOLD;
            HOLD: begin
                w_next_count = r_count + 1'b1;
                if (r_count == c_last_count) begin
                    w_next_state = DONE;
                end else begin
                    w_next_addr  = r_addr + 1'b1;
                    w_next_state = RECV_LO;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they line up with
    // the state they describe while still coming straight out of flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_lo_byte    <= '0;
            r_addr       <= '0;
            r_count      <= '0;
            r_dq         <= '0;
            r_byte_ready <= 1'b0;
            r_dq_oe      <= 1'b0;
            r_we_n       <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_lo_byte    <= w_next_lo_byte;
            r_addr       <= w_next_addr;
            r_count      <= w_next_count;
            r_dq         <= w_next_dq;
            r_byte_ready <= (w_next_state == RECV_LO) || (w_next_state == RECV_HI);
            r_dq_oe      <= (w_next_state == SETUP) || (w_next_state == WRITE) ||
                            (w_next_state == HOLD);
            r_we_n       <= (w_next_state != WRITE);
            r_busy       <= (w_next_state != IDLE) && (w_next_state != DONE);
            r_done       <= (w_next_state == DONE);
        end
    end

    assign o_byte_ready = r_byte_ready;
    assign o_SRAM_ADDR  = r_addr;
    assign o_SRAM_DQ    = r_dq;
    assign o_SRAM_DQ_OE = r_dq_oe;
    assign o_SRAM_WE_N  = r_we_n;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_word_count = r_count;

endmodule : sram_frame_loader

`default_nettype wire

// File: tb/tb_sram_frame_loader.sv
// ============================================================================
// Module      : tb_sram_frame_loader
// Description : Self-checking bench for sram_frame_loader with a queue-based
//               model of expected SRAM writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_frame_loader;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int WC = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq;
    logic          sram_dq_oe;
    logic          sram_we_n;
    logic          busy;
    logic          done;
    logic [AW-1:0] word_count;

    int  n_checks = 0;
    int  n_fails  = 0;
    wr_t exp_q[$];
    int  m_addr;

    sram_frame_loader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .WORD_COUNT(WC)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_byte       (byte_in),
        .i_byte_valid (byte_valid),
        .o_byte_ready (byte_ready),
        .o_SRAM_ADDR  (sram_addr),
        .o_SRAM_DQ    (sram_dq),
        .o_SRAM_DQ_OE (sram_dq_oe),
        .o_SRAM_WE_N  (sram_we_n),
        .o_busy       (busy),
        .o_done       (done),
        .o_word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Write monitor: every WE_N low cycle must match the next modelled write
    // and be framed by OE high with WE_N high on both sides.
    logic prev_we_n = 1'b1;
    logic prev_oe   = 1'b0;
    logic pending   = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            prev_we_n <= 1'b1;
            prev_oe   <= 1'b0;
        end else begin
            if (pending) begin
                check("we_n_after_pulse", 32'(sram_we_n), 32'd1);
                check("oe_after_pulse", 32'(sram_dq_oe), 32'd1);
            end
            if (!sram_we_n) begin
                check("oe_during_we", 32'(sram_dq_oe), 32'd1);
                check("oe_before_we", 32'(prev_oe), 32'd1);
                check("we_n_before_pulse", 32'(prev_we_n), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(sram_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(sram_addr), 32'(e.addr));
                    check("wr_data", 32'(sram_dq), 32'(e.data));
                end
            end
            pending   <= !sram_we_n;
            prev_we_n <= sram_we_n;
            prev_oe   <= sram_dq_oe;
        end
    end

    // Tasks enter and leave just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok         = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int c = 0; c < 64 && !ok; c++) begin
            if (byte_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
        if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [7:0] lo, input logic [7:0] hi,
                             input int gap, input bit pulse_start);
        exp_q.push_back('{addr: AW'(m_addr), data: {hi, lo}});
        m_addr++;
        send_byte(lo);
        for (int i = 0; i < gap; i++) begin
            start = pulse_start && (i == gap / 2);
            @(negedge clk);
        end
        start = 1'b0;
        if (gap > 0) begin
            check("stall_we_n", 32'(sram_we_n), 32'd1);
            check("stall_oe", 32'(sram_dq_oe), 32'd0);
            check("stall_ready", 32'(byte_ready), 32'd1);
        end
        if (pulse_start) check("start_ignored_busy", 32'(busy), 32'd1);
        send_byte(hi);
    endtask

    task automatic start_load();
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        m_addr = 0;
        check("start_done_low", 32'(done), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        check("start_addr", 32'(sram_addr), 32'd0);
        check("start_word_count", 32'(word_count), 32'd0);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 64 && !ok; c++) begin
            if (done) ok = 1'b1;
            else @(negedge clk);
        end
        check("done_timeout", 32'(ok), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_oe", 32'(sram_dq_oe), 32'd0);
        check("done_we_n", 32'(sram_we_n), 32'd1);
        check("done_word_count", 32'(word_count), 32'(WC));
        check("done_writes_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h5A;
        byte_valid = 1'b1;
        m_addr     = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq", 32'(sram_dq), 32'd0);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_ready", 32'(byte_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        byte_valid = 1'b0;

        // Directed little-endian packing, back-to-back bytes.
        start_load();
        send_word(8'h34, 8'h12, 0, 1'b0);
        send_word(8'hCD, 8'hAB, 0, 1'b0);
        wait_done();

        // Stall between halves, then i_start during RECV_HI of word 1.
        start_load();
        send_word(8'($urandom), 8'($urandom), 10, 1'b0);
        send_word(8'($urandom), 8'($urandom), 4, 1'b1);
        wait_done();

        // Restart from DONE.
        start_load();
        send_word(8'hFF, 8'h00, 0, 1'b0);
        send_word(8'($urandom), 8'($urandom), 0, 1'b0);
        wait_done();

        for (int l = 0; l < 4; l++) begin
            start_load();
            for (int w = 0; w < WC; w++)
                send_word(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
            wait_done();
        end

        // Asynchronous reset while WE_N is low.
        start_load();
        send_word(8'($urandom), 8'($urandom), 0, 1'b0);
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 16 && !seen; c++) begin
                if (!sram_we_n) seen = 1'b1;
                else @(negedge clk);
            end
            check("reach_write_timeout", 32'(seen), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_we_n", 32'(sram_we_n), 32'd1);
        check("midrst_oe", 32'(sram_dq_oe), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_addr", 32'(sram_addr), 32'd0);
        check("midrst_word_count", 32'(word_count), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_load();
        for (int w = 0; w < WC; w++)
            send_word(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
        wait_done();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_sram_frame_loader

`default_nettype wire

// File: doc/sram_frame_loader.md
Name: sram_frame_loader

Overview:
- Write-side counterpart of the Renderer's SRAM read path. Before a game starts, it takes an 8-bit byte stream from the host or UART bridge and fills SRAM with background and sprite pixel words.
- Packs byte pairs into 16-bit words and writes them to sequential addresses from 0, using an explicit WE_N pulse and a DQ output enable.
- Sits in top beside the Renderer. A top-level mux gives it SRAM ownership while o_busy=1.

Parameters:
- ADDR_WIDTH, 20, SRAM address width; equals sram_param::SRAM_ADDR_COUNT.
- DATA_WIDTH, 16, SRAM word width; equals sram_param::SRAM_DATA_WIDTH. Fixed at 2 bytes.
- WORD_COUNT, 307200, number of words written per load (640x480).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle pulse; begins a load from address 0.
- i_byte  in  8  stream data byte.
- i_byte_valid  in  1  i_byte is valid this cycle.
- o_byte_ready  out  1  loader can accept a byte this cycle.
- o_SRAM_ADDR  out  ADDR_WIDTH  write address.
- o_SRAM_DQ  out  DATA_WIDTH  write data; top drives io_SRAM_DQ with it when o_SRAM_DQ_OE=1.
- o_SRAM_DQ_OE  out  1  DQ output enable.
- o_SRAM_WE_N  out  1  SRAM write enable, active-low.
- o_busy  out  1  load in progress; the loader owns SRAM.
- o_done  out  1  load complete; held high until the next i_start.
- o_word_count  out  ADDR_WIDTH  number of words written so far.

Behaviour:
- Reset values: o_byte_ready=0, o_SRAM_ADDR=0, o_SRAM_DQ=0, o_SRAM_DQ_OE=0, o_SRAM_WE_N=1, o_busy=0, o_done=0, o_word_count=0, state IDLE.
- All outputs are registered.
- Byte transfer: a byte is accepted only when i_byte_valid && o_byte_ready in the same cycle.
  - o_byte_ready=1 only in RECV_LO and RECV_HI.
  - o_byte_ready does not depend combinationally on i_byte_valid.
- Word format: the first byte accepted is bits [7:0], the second is bits [15:8] (little-endian).
- FSM states and transitions:
  - IDLE: on i_start, go to RECV_LO. Clear address, o_word_count and o_done. Set o_busy=1.
  - RECV_LO: on accept, latch the low byte, go to RECV_HI.
  - RECV_HI: on accept, latch the high byte, go to SETUP.
  - SETUP: o_SRAM_DQ=packed word, o_SRAM_DQ_OE=1, o_SRAM_WE_N=1, address stable. Go to WRITE.
  - WRITE: o_SRAM_WE_N=0 for exactly one cycle; address and data held. Go to HOLD.
  - HOLD: o_SRAM_WE_N=1; address, data and OE held. Increment o_word_count.
    - If o_word_count+1 == WORD_COUNT, go to DONE.
    - Otherwise increment the address and go to RECV_LO.
  - DONE: o_SRAM_DQ_OE=0, o_busy=0, o_done=1. On i_start, go to RECV_LO (same actions as from IDLE).
- Throughput: at least 5 cycles per word (2 accept cycles, then SETUP, WRITE, HOLD).
- Latency: byte2 accepted at cycle t gives WE_N low at t+2.
- Stalls: if i_byte_valid=0 in RECV_LO or RECV_HI, the FSM waits indefinitely. Outputs hold, WE_N=1, OE=0.
- i_start while o_busy=1 is ignored; it does not restart the load.
- Simultaneous events: i_start in the same cycle as the final HOLD gives DONE next cycle. That i_start is not latched.
- Address width: the address counter never wraps within a load because WORD_COUNT <= 2^ADDR_WIDTH. It is reset to 0 by i_start.
- Bus safety: o_SRAM_WE_N is never 0 while o_SRAM_DQ_OE=0. OE rises one cycle before the WE_N falling edge and falls at least one cycle after the WE_N rising edge.
- Reset mid-operation: asynchronous reset immediately forces the reset values above. WE_N=1 and OE=0 guarantee no partial write. The partial byte is discarded.

Decomposition:
- sram_param package: add typedef enum LoaderState {IDLE, RECV_LO, RECV_HI, SETUP, WRITE, HOLD, DONE} and constant FRAME_WORD_COUNT=307200.
- Reuse SRAM_ADDR_COUNT and SRAM_DATA_WIDTH from the same package.
- No sub-module. Byte packing and the write pulse fit in one FSM.

Test Plan:
- Reset then idle: all outputs at reset values; o_byte_ready=0 while i_byte_valid=1.
- WORD_COUNT=2, i_start, bytes 0x34,0x12,0xCD,0xAB back-to-back:
  - writes 0x1234@0, then 0xABCD@1.
  - each WE_N low pulse lasts exactly 1 cycle with OE=1 the cycle before and after.
  - afterwards o_done=1, o_word_count=2, OE=0.
- Stall: deassert i_byte_valid for 10 cycles between the low and high byte → no WE_N pulse. Data written after the stall is still correctly packed.
- i_start pulsed during the RECV_HI of word 1 → ignored. Address continues to 1; the load is not restarted.
- Assert i_rst_n=0 during WRITE → WE_N=1 and OE=0 immediately. After release, a new i_start writes from address 0.
- After DONE, a second i_start with 0xFF,0x00 → writes 0x00FF@0. o_done falls the cycle after i_start.
